fp_int_serial_mul: RTL and testbench

Parametrised bit-serial multiplier of a floating-point activation by a signed two's-complement integer weight, streamed MSB first with a per-operation precision. It generalises the fixed fp16 × int4 multiplier in several ways: configurable exponent and mantissa widths, precision from 1 to MAX_PRECISION, correct signed weights, ready/valid handshakes with stalls, special-value flags and optional normalisation. It sits between the activation/weight feeders and the accumulator of each MAC lane.

---
 rtl/fp_int_pkg.sv | 20 ++
 rtl/fp_lzd.sv | 26 ++
 rtl/fp_int_serial_mul.sv | 209 ++++++++++++++++++++
 tb/tb_fp_int_serial_mul.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_int_pkg.sv
// Shared defaults, width derivation and FSM state type for the bit-serial
// floating-point x integer multiplier.
package fp_int_pkg;

    localparam int EXP_W_DEF         = 5;
    localparam int MAN_W_DEF         = 10;
    localparam int MAX_PRECISION_DEF = 8;

    // Magnitude width: hidden bit + stored mantissa + widest weight.
    function automatic int prodWidth(input int manW, input int maxPrecision);
        return manW + 1 + maxPrecision;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/fp_lzd.sv
// Leading-one detector: index of the highest set bit plus a non-zero flag.
// Only compiled and used when FP_INT_MUL_NORM_EN is defined.
`ifdef FP_INT_MUL_NORM_EN
module fp_lzd #(
    parameter int W     = 19,
    parameter int POS_W = $clog2(W)
) (
    input  logic [W-1:0]     i_vec,
    output logic [POS_W-1:0] o_pos,
    output logic             o_valid
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        o_pos   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i_vec[i]) begin
                o_pos   = POS_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/fp_int_serial_mul.sv
// Bit-serial multiply of a float activation by a signed weight streamed MSB first.
// Define FP_INT_MUL_NORM_EN to left-justify the magnitude and rebase the exponent.
module fp_int_serial_mul
    import fp_int_pkg::*;
#(
    parameter int EXP_W         = EXP_W_DEF,
    parameter int MAN_W         = MAN_W_DEF,
    parameter int MAX_PRECISION = MAX_PRECISION_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [EXP_W+MAN_W:0]         act,
    input  logic [3:0]                   precision,
    input  logic                         w_valid,
    input  logic                         w,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sign,
    output logic [EXP_W+1:0]             out_exp,
    output logic [MAN_W+MAX_PRECISION:0] out_mant,
    output logic                         out_zero,
    output logic                         out_special
);

    localparam int         ACT_W  = 1 + EXP_W + MAN_W;
    localparam int         PROD_W = prodWidth(MAN_W, MAX_PRECISION);
    localparam int         ACC_W  = PROD_W + 1;
    localparam int         OEXP_W = EXP_W + 2;
    localparam logic [3:0] MAXP   = 4'(MAX_PRECISION);

    state_t                   r_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic [MAN_W:0]           r_mant;
    logic [EXP_W-1:0]         r_expEff;
    logic                     r_actSign;
    logic                     r_special;
    logic                     r_first;
    logic [3:0]               r_cnt;

    logic [EXP_W-1:0]         w_exp;
    logic [MAN_W-1:0]         w_man;
    logic [3:0]               w_prec;
    logic signed [ACC_W-1:0]  w_mExt;
    logic signed [ACC_W-1:0]  w_addend;
    logic signed [ACC_W-1:0]  w_accNext;
    logic signed [ACC_W-1:0]  w_srcAcc;
    logic [PROD_W-1:0]        w_mag;
    logic                     w_isZero;
    logic                     w_resSign;
    logic [OEXP_W-1:0]        w_outExp;
    logic [PROD_W-1:0]        w_outMant;

    assign w_exp = act[ACT_W-2 -: EXP_W];
    assign w_man = act[MAN_W-1:0];

    always_comb begin
        w_prec = precision;
        if (precision == 4'd0) begin
            w_prec = 4'd1;
        end else if (precision > MAXP) begin
            w_prec = MAXP;
        end
    end

    // The first bit carries negative weight: it is the two's-complement MSB.
    assign w_mExt = {{(ACC_W-MAN_W-1){1'b0}}, r_mant};
    always_comb begin
        w_addend = '0;
        if (w) begin
            w_addend = r_first ? -w_mExt : w_mExt;
        end
    end
    assign w_accNext = (r_acc <<< 1) + w_addend;

`ifdef FP_INT_MUL_NORM_EN
    localparam int LZ_W = $clog2(PROD_W);

    logic              r_normPend;
    logic [LZ_W-1:0]   w_lead;
    logic              w_leadValid;
    logic [OEXP_W-1:0] w_expNorm;

    assign w_srcAcc = r_acc;
`else
    assign w_srcAcc = w_accNext;
`endif

    assign w_mag     = w_srcAcc[ACC_W-1] ? PROD_W'(-w_srcAcc) : PROD_W'(w_srcAcc);
    assign w_isZero  = (w_mag == '0);
    assign w_resSign = (r_actSign ^ w_srcAcc[ACC_W-1]) & ~w_isZero;

`ifdef FP_INT_MUL_NORM_EN
    fp_lzd #(
        .W     (PROD_W),
        .POS_W (LZ_W)
    ) u_lzd (
        .i_vec   (w_mag),
        .o_pos   (w_lead),
        .o_valid (w_leadValid)
    );

    assign w_expNorm = OEXP_W'(int'(r_expEff) + int'(w_lead) - MAN_W);

    always_comb begin
        w_outMant = '0;
        w_outExp  = '0;
        if (w_leadValid) begin
            w_outMant = w_mag << (LZ_W'(PROD_W - 1) - w_lead);
            w_outExp  = w_expNorm;
        end
        if (r_special) begin
            w_outMant = '0;
            w_outExp  = '1;
        end
    end
`else
    always_comb begin
        w_outMant = w_mag;
        w_outExp  = {2'b00, r_expEff};
        if (r_special) begin
            w_outMant = '0;
            w_outExp  = '1;
        end
    end
`endif

    // Control FSM; all outputs are registered and frozen while DONE waits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_mant      <= '0;
            r_expEff    <= '0;
            r_actSign   <= 1'b0;
            r_special   <= 1'b0;
            r_first     <= 1'b0;
            r_cnt       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_sign    <= 1'b0;
            out_exp     <= '0;
            out_mant    <= '0;
            out_zero    <= 1'b0;
            out_special <= 1'b0;
`ifdef FP_INT_MUL_NORM_EN
            r_normPend  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state   <= SHIFT;
                        in_ready  <= 1'b0;
                        r_acc     <= '0;
                        r_cnt     <= w_prec;
                        r_first   <= 1'b1;
                        r_actSign <= act[ACT_W-1];
                        r_special <= &w_exp;
                        r_expEff  <= (w_exp == '0) ? EXP_W'(1) : w_exp;
                        r_mant    <= {|w_exp, w_man};
                    end
                end
                SHIFT: begin
                    if (w_valid) begin
                        r_acc   <= w_accNext;
                        r_first <= 1'b0;
                        r_cnt   <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state     <= DONE;
`ifdef FP_INT_MUL_NORM_EN
                            r_normPend  <= 1'b1;
`else
                            out_valid   <= 1'b1;
                            out_sign    <= w_resSign;
                            out_exp     <= w_outExp;
                            out_mant    <= w_outMant;
                            out_zero    <= w_isZero;
                            out_special <= r_special;
`endif
                        end
                    end
                end
                DONE: begin
`ifdef FP_INT_MUL_NORM_EN
                    if (r_normPend) begin
                        r_normPend  <= 1'b0;
                        out_valid   <= 1'b1;
                        out_sign    <= w_resSign;
                        out_exp     <= w_outExp;
                        out_mant    <= w_outMant;
                        out_zero    <= w_isZero;
                        out_special <= r_special;
                    end else if (out_ready) begin
`else
                    if (out_ready) begin
`endif
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_int_serial_mul.sv
// Self-checking bench for fp_int_serial_mul: integer-product reference model,
// per-cycle output compare, directed corner cases and randomized operations.
`timescale 1ns/1ps
module tb_fp_int_serial_mul;

`ifdef FP_INT_MUL_NORM_EN
    localparam bit NORM = 1'b1;
`else
    localparam bit NORM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] act;
    logic [3:0]  precision;
    logic        w_valid;
    logic        w;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [6:0]  out_exp;
    logic [18:0] out_mant;
    logic        out_zero;
    logic        out_special;

    always #5 clk = ~clk;

    fp_int_serial_mul dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .act         (act),
        .precision   (precision),
        .w_valid     (w_valid),
        .w           (w),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sign    (out_sign),
        .out_exp     (out_exp),
        .out_mant    (out_mant),
        .out_zero    (out_zero),
        .out_special (out_special)
    );

    typedef struct {
        logic        s;
        logic [6:0]  e;
        logic [18:0] m;
        logic        z;
        logic        sp;
    } res_t;

    res_t q[$];
    res_t head;
    int   nVec = 0;
    int   nMis = 0;
    int   cyc = 0;
    int   acceptCyc = 0;
    int   riseCyc = 0;
    logic forceLow = 1'b0;
    logic prevValid = 1'b0;
    logic        lastSign, lastZero, lastSpecial;
    logic [6:0]  lastExp;
    logic [18:0] lastMant;

    always @(posedge clk) cyc++;

    // Result = activation significand times the signed weight value, as plain integers.
    function automatic res_t model(input logic [15:0] a, input logic [3:0] p, input logic [7:0] wb);
        res_t r;
        int pe, wv, ex, mn, m, ee, prod, mag, lead;
        pe = (p == 4'd0) ? 1 : ((p > 4'd8) ? 8 : int'(p));
        wv = 0;
        for (int i = pe - 1; i >= 0; i--) wv = wv * 2 + int'(wb[i]);
        if (wb[pe-1]) wv -= (1 << pe);
        ex   = int'(a[14:10]);
        mn   = int'(a[9:0]);
        m    = (ex == 0) ? mn : mn + 1024;
        ee   = (ex == 0) ? 1 : ex;
        prod = m * wv;
        mag  = (prod < 0) ? -prod : prod;
        r.z  = (mag == 0);
        r.sp = (ex == 31);
        r.s  = (mag != 0) && (a[15] ^ (prod < 0));
        if (NORM) begin
            if (mag == 0) begin
                r.m = '0;
                r.e = '0;
            end else begin
                lead = 0;
                while ((mag >> (lead + 1)) != 0) lead++;
                r.m = 19'(mag << (18 - lead));
                r.e = 7'(ee + lead - 10);
            end
        end else begin
            r.m = 19'(mag);
            r.e = 7'(ee);
        end
        if (r.sp) begin
            r.m = '0;
            r.e = 7'h7f;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Compare every cycle out_valid is high; the head is retired when out_ready completes the handshake.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (!prevValid) riseCyc = cyc;
            if (q.size() == 0) begin
                checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                head = q[0];
                checkOutput("out_sign", 32'(out_sign), 32'(head.s));
                checkOutput("out_exp", 32'(out_exp), 32'(head.e));
                checkOutput("out_mant", 32'(out_mant), 32'(head.m));
                checkOutput("out_zero", 32'(out_zero), 32'(head.z));
                checkOutput("out_special", 32'(out_special), 32'(head.sp));
                checkOutput("in_ready_low", 32'(in_ready), 32'd0);
                if (out_ready) begin
                    lastSign    = out_sign;
                    lastExp     = out_exp;
                    lastMant    = out_mant;
                    lastZero    = out_zero;
                    lastSpecial = out_special;
                    void'(q.pop_front());
                end
            end
        end
        prevValid = out_valid;
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = forceLow ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // abortAt >= 0 asserts reset while that bit (0 = first) is on the wire and leaves rst low.
    task automatic applyStimulus(input logic [15:0] a, input logic [3:0] p, input logic [7:0] wb,
                                 input int maxGap, input int abortAt);
        int pe, budget, gap;
        pe = (p == 4'd0) ? 1 : ((p > 4'd8) ? 8 : int'(p));
        budget = 0;
        @(posedge clk);
        #1;
        while (!in_ready && budget < 300) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid  = 1'b1;
        act       = a;
        precision = p;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        acceptCyc = cyc;
        q.push_back(model(a, p, wb));
        for (int i = pe - 1; i >= 0; i--) begin
            gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
            repeat (gap) begin
                w_valid = 1'b0;
                w       = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            w_valid = 1'b1;
            w       = wb[i];
            if (pe - 1 - i == abortAt) begin
                #2;
                rst = 1'b0;
                q.delete();
                w_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        // Junk bits outside SHIFT must be ignored.
        w_valid = 1'b1;
        w       = 1'b1;
    endtask

    task automatic waitIdle();
        int b;
        b = 0;
        while (q.size() != 0 && b < 400) begin
            @(negedge clk);
            b++;
        end
        if (q.size() != 0) begin
            checkOutput("result_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int b;
        rst = 1'b0; in_valid = 1'b0; act = '0; precision = '0; w_valid = 1'b0; w = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_mant", 32'(out_mant), 32'd0);
        checkOutput("rst_out_exp", 32'(out_exp), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 1.0 x 7; out_valid first seen P edges after the handshake edge (one more when normalising).
        applyStimulus(16'h3C00, 4'd4, 8'b0111, 0, -1);
        waitIdle();
        checkOutput("t1_latency", 32'(riseCyc - acceptCyc), NORM ? 32'd5 : 32'd4);
        checkOutput("t1_sign", 32'(lastSign), 32'd0);
        checkOutput("t1_exp", 32'(lastExp), NORM ? 32'd17 : 32'd15);
        checkOutput("t1_mant", 32'(lastMant), NORM ? 32'd458752 : 32'd7168);

        // Negative activation times -8, and a 1-bit weight of -1.
        applyStimulus(16'hBC00, 4'd4, 8'b1000, 1, -1);
        waitIdle();
        checkOutput("t2_sign", 32'(lastSign), 32'd0);
        checkOutput("t2_mant", 32'(lastMant), NORM ? 32'd262144 : 32'd8192);
        applyStimulus(16'hBC00, 4'd1, 8'b1, 0, -1);
        waitIdle();
        checkOutput("t2b_sign", 32'(lastSign), 32'd0);
        checkOutput("t2b_mant", 32'(lastMant), NORM ? 32'd262144 : 32'd1024);

        // Largest magnitude, then precision clamps 0 -> 1 and 12 -> 8.
        applyStimulus(16'h7BFF, 4'd8, 8'h80, 0, -1);
        waitIdle();
        checkOutput("t3_sign", 32'(lastSign), 32'd1);
        checkOutput("t3_mant", 32'(lastMant), NORM ? 32'd524032 : 32'd262016);
        applyStimulus(16'h3C00, 4'd0, 8'b1, 0, -1);
        waitIdle();
        checkOutput("t3_p0_sign", 32'(lastSign), 32'd1);
        checkOutput("t3_p0_mant", 32'(lastMant), NORM ? 32'd262144 : 32'd1024);
        applyStimulus(16'h3C00, 4'd12, 8'h81, 0, -1);
        waitIdle();
        checkOutput("t3_p12_mant", 32'(lastMant), NORM ? 32'd520192 : 32'd130048);

        // Stalled weight stream and a held result, then a back-to-back operation.
        forceLow = 1'b1;
        applyStimulus(16'h4500, 4'd6, 8'b101101, 3, -1);
        b = 0;
        while (!out_valid && b < 100) begin
            @(negedge clk);
            b++;
        end
        checkOutput("t4_out_valid", 32'(out_valid), 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("t4_held_valid", 32'(out_valid), 32'd1);
        forceLow = 1'b0;
        applyStimulus(16'hC123, 4'd5, 8'($urandom), 0, -1);
        waitIdle();

        // Reset during the second bit aborts the operation.
        applyStimulus(16'h3C00, 4'd4, 8'b0001, 0, 1);
        @(negedge clk);
        checkOutput("t5_in_ready", 32'(in_ready), 32'd1);
        checkOutput("t5_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_out_sign", 32'(out_sign), 32'd0);
        checkOutput("t5_out_mant", 32'(out_mant), 32'd0);
        checkOutput("t5_out_exp", 32'(out_exp), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(16'h3C00, 4'd4, 8'b0001, 0, -1);
        waitIdle();
        checkOutput("t5_mant", 32'(lastMant), NORM ? 32'd262144 : 32'd1024);

        // Special, zero and subnormal activations.
        applyStimulus(16'h7C00, 4'd4, 8'b0101, 0, -1);
        waitIdle();
        checkOutput("t6_special", 32'(lastSpecial), 32'd1);
        checkOutput("t6_special_mant", 32'(lastMant), 32'd0);
        applyStimulus(16'h8000, 4'd4, 8'b1011, 0, -1);
        waitIdle();
        checkOutput("t6_zero", 32'(lastZero), 32'd1);
        checkOutput("t6_zero_sign", 32'(lastSign), 32'd0);
        applyStimulus(16'h0001, 4'd4, 8'b0011, 0, -1);
        waitIdle();
        checkOutput("t6_sub_mant", 32'(lastMant), NORM ? 32'd393216 : 32'd3);
        checkOutput("t6_sub_exp", 32'(lastExp), NORM ? 32'd120 : 32'd1);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(16'($urandom), 4'($urandom_range(0, 15)), 8'($urandom), 2, -1);
        end
        waitIdle();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
